ticket_issuer: RTL and testbench

TICKET_ISSUER -- requirements
Module: ticket_issuer

---
 rtl/ticket_defs.sv | 23 ++
 rtl/pulse_timer.sv | 34 +++
 rtl/ticket_issuer.sv | 211 +++++++++++++++++++++
 tb/tb_ticket_issuer.sv | 252 +++++++++++++++++++++++++
 4 files changed

// File: rtl/ticket_defs.sv
// rtl/ticket_defs.sv - shared constants and FSM encodings for the ticket issuer
//
// Purpose: holds the dispense FSM state encoding, the default sizing values
// and a helper that derives the ticket-type index width.
package ticket_defs;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_HIGH = 2'd1,
    ST_LOW  = 2'd2,
    ST_FIN  = 2'd3
  } state_e;

  localparam int DEF_N_TYPES = 4;
  localparam int DEF_CNT_W   = 3;
  localparam int DEF_STOCK_W = 8;

  // Type index width: clog2(n), never narrower than one bit.
  function automatic int type_w(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/pulse_timer.sv
// rtl/pulse_timer.sv - loadable down-counter timing the HIGH/LOW phases
//
// Purpose: loaded with (phase length - 1) on entry to a phase; expire_o is
// high during the last cycle of that phase.
// Ports:
//   clk, rst      clock, asynchronous active-high reset
//   load_i        load load_val_i this edge (takes priority over counting)
//   load_val_i    value to load
//   expire_o      counter has reached zero
module pulse_timer #(
  parameter int W = 2
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load_i,
  input  logic [W-1:0] load_val_i,
  output logic         expire_o
);

  logic [W-1:0] cnt_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
    end else if (load_i) begin
      cnt_q <= load_val_i;
    end else if (cnt_q != '0) begin
      cnt_q <= cnt_q - 1'b1;
    end
  end

  assign expire_o = (cnt_q == '0);

endmodule

// File: rtl/ticket_issuer.sv
// rtl/ticket_issuer.sv - ticket dispenser with per-type stock and pulsed issue lines
//
// Purpose: accepts purchase requests, checks stock, then emits one pulse per
// ticket on issue[type]; supports abort with refund and saturating restock.
// Ports:
//   clk, rst                 clock, asynchronous active-high reset
//   req_valid/req_ready      purchase handshake (ready only in IDLE)
//   req_type, req_count      ticket type and quantity, sampled at acceptance
//   abort                    cancel the dispense in progress
//   restock_valid/_type/_amt add stock to one type (any state)
//   issue                    per-type ticket pulses
//   busy, done, err, aborted status / one-cycle result pulses
//   stock                    flattened per-type stock counters
module ticket_issuer
  import ticket_defs::*;
#(
  parameter int N_TYPES    = DEF_N_TYPES,
  parameter int CNT_W      = DEF_CNT_W,
  parameter int STOCK_W    = DEF_STOCK_W,
  parameter int STOCK_INIT = 20,
  parameter int PULSE_HI   = 1,
  parameter int PULSE_LO   = 1
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          req_valid,
  output logic                          req_ready,
  input  logic [type_w(N_TYPES)-1:0]    req_type,
  input  logic [CNT_W-1:0]              req_count,
  input  logic                          abort,
  input  logic                          restock_valid,
  input  logic [type_w(N_TYPES)-1:0]    restock_type,
  input  logic [STOCK_W-1:0]            restock_amt,
  output logic [N_TYPES-1:0]            issue,
  output logic                          busy,
  output logic                          done,
  output logic                          err,
  output logic                          aborted,
  output logic [N_TYPES*STOCK_W-1:0]    stock
);

  localparam int TW        = type_w(N_TYPES);
  localparam int PHASE_MAX = (PULSE_HI > PULSE_LO) ? PULSE_HI : PULSE_LO;
  localparam int TMR_W     = $clog2(PHASE_MAX) + 1;
  // Wide enough for stock + restock + refund without overflow.
  localparam int SUM_W     = ((STOCK_W > CNT_W) ? STOCK_W : CNT_W) + 2;

  localparam logic [TMR_W-1:0]   HI_M1     = TMR_W'(PULSE_HI - 1);
  localparam logic [TMR_W-1:0]   LO_M1     = TMR_W'(PULSE_LO - 1);
  localparam logic [TW:0]        N_LIM     = (TW + 1)'(N_TYPES);
  localparam logic [STOCK_W-1:0] STOCK_MAX = {STOCK_W{1'b1}};
  localparam logic [STOCK_W-1:0] STOCK_RST = STOCK_W'(STOCK_INIT);

  state_e             state_q, state_d;
  logic [TW-1:0]      type_q, type_d;
  logic [CNT_W-1:0]   rem_q, rem_d;
  logic               err_q, err_d;
  logic               aborted_q, aborted_d;
  logic [STOCK_W-1:0] stock_q [N_TYPES];
  logic [STOCK_W-1:0] stock_d [N_TYPES];

  logic               tmr_load;
  logic [TMR_W-1:0]   tmr_val;
  logic               tmr_expire;

  logic               accept;
  logic               type_ok;
  logic [STOCK_W-1:0] sel_stock;
  logic               req_ok;
  logic               take;
  logic               abort_fire;
  logic [CNT_W-1:0]   refund;

  pulse_timer #(.W(TMR_W)) u_pulse_timer (
    .clk        (clk),
    .rst        (rst),
    .load_i     (tmr_load),
    .load_val_i (tmr_val),
    .expire_o   (tmr_expire)
  );

  // Acceptance check against pre-edge stock of the requested type.
  always_comb begin
    sel_stock = '0;
    for (int i = 0; i < N_TYPES; i++) begin
      if (req_type == TW'(i)) sel_stock = stock_q[i];
    end
  end

  assign accept  = (state_q == ST_IDLE) && req_valid;
  assign type_ok = ({1'b0, req_type} < N_LIM);
  assign req_ok  = type_ok && (req_count != '0) && (SUM_W'(sel_stock) >= SUM_W'(req_count));
  assign take    = accept && req_ok;
  assign err_d   = accept && !req_ok;

  // The ticket currently in HIGH is treated as issued, so it is not refunded.
  assign abort_fire = abort && ((state_q == ST_HIGH) || (state_q == ST_LOW));
  assign refund     = (state_q == ST_HIGH) ? (rem_q - 1'b1) : rem_q;
  assign aborted_d  = abort_fire;

  always_comb begin
    state_d  = state_q;
    type_d   = type_q;
    rem_d    = rem_q;
    tmr_load = 1'b0;
    tmr_val  = HI_M1;
    case (state_q)
      ST_IDLE: begin
        if (take) begin
          type_d   = req_type;
          rem_d    = req_count;
          state_d  = ST_HIGH;
          tmr_load = 1'b1;
          tmr_val  = HI_M1;
        end
      end
      ST_HIGH: begin
        if (abort) begin
          state_d = ST_IDLE;
          rem_d   = '0;
        end else if (tmr_expire) begin
          rem_d    = rem_q - 1'b1;
          state_d  = ST_LOW;
          tmr_load = 1'b1;
          tmr_val  = LO_M1;
        end
      end
      ST_LOW: begin
        if (abort) begin
          state_d = ST_IDLE;
          rem_d   = '0;
        end else if (tmr_expire) begin
          if (rem_q != '0) begin
            state_d  = ST_HIGH;
            tmr_load = 1'b1;
            tmr_val  = HI_M1;
          end else begin
            state_d = ST_FIN;
          end
        end
      end
      ST_FIN: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      type_q    <= '0;
      rem_q     <= '0;
      err_q     <= 1'b0;
      aborted_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      type_q    <= type_d;
      rem_q     <= rem_d;
      err_q     <= err_d;
      aborted_q <= aborted_d;
    end
  end

  // One adder/subtractor per type: restock, acceptance debit and abort refund
  // all fold into a single sum, saturated at the counter maximum.
  for (genvar g = 0; g < N_TYPES; g++) begin : g_stock
    localparam logic [TW-1:0] IDX = TW'(g);
    logic [SUM_W-1:0] add_v;
    logic [SUM_W-1:0] sub_v;
    logic [SUM_W-1:0] sum_v;

    always_comb begin
      add_v = '0;
      sub_v = '0;
      if (restock_valid && (restock_type == IDX)) add_v = add_v + SUM_W'(restock_amt);
      if (abort_fire && (type_q == IDX))          add_v = add_v + SUM_W'(refund);
      if (take && (req_type == IDX))              sub_v = SUM_W'(req_count);
      sum_v = SUM_W'(stock_q[g]) + add_v - sub_v;
      stock_d[g] = (sum_v > SUM_W'(STOCK_MAX)) ? STOCK_MAX : sum_v[STOCK_W-1:0];
    end

    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        stock_q[g] <= STOCK_RST;
      end else begin
        stock_q[g] <= stock_d[g];
      end
    end

    assign stock[g*STOCK_W +: STOCK_W] = stock_q[g];
  end

  always_comb begin
    issue = '0;
    if (state_q == ST_HIGH) begin
      for (int i = 0; i < N_TYPES; i++) begin
        if (type_q == TW'(i)) issue[i] = 1'b1;
      end
    end
  end

  assign req_ready = (state_q == ST_IDLE);
  assign busy      = (state_q == ST_HIGH) || (state_q == ST_LOW);
  assign done      = (state_q == ST_FIN);
  assign err       = err_q;
  assign aborted   = aborted_q;

endmodule

// File: tb/tb_ticket_issuer.sv
// tb/tb_ticket_issuer.sv - self-checking bench for ticket_issuer
module tb_ticket_issuer;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic       rv [2];
  logic [2:0] rt [2];
  logic [2:0] rc [2];
  logic       ab [2];
  logic       sv [2];
  logic [2:0] st [2];
  logic [7:0] sa [2];

  logic        rdy_a, busy_a, done_a, err_a, abt_a;
  logic [3:0]  iss_a;
  logic [31:0] stk_a;
  logic        rdy_b, busy_b, done_b, err_b, abt_b;
  logic [4:0]  iss_b;
  logic [39:0] stk_b;

  int n_checks = 0;
  int n_err    = 0;

  ticket_issuer u_dut_a (
    .clk(clk), .rst(rst),
    .req_valid(rv[0]), .req_ready(rdy_a), .req_type(rt[0][1:0]), .req_count(rc[0]),
    .abort(ab[0]), .restock_valid(sv[0]), .restock_type(st[0][1:0]), .restock_amt(sa[0]),
    .issue(iss_a), .busy(busy_a), .done(done_a), .err(err_a), .aborted(abt_a), .stock(stk_a)
  );

  ticket_issuer #(.N_TYPES(5), .PULSE_HI(3), .PULSE_LO(2)) u_dut_b (
    .clk(clk), .rst(rst),
    .req_valid(rv[1]), .req_ready(rdy_b), .req_type(rt[1]), .req_count(rc[1]),
    .abort(ab[1]), .restock_valid(sv[1]), .restock_type(st[1]), .restock_amt(sa[1]),
    .issue(iss_b), .busy(busy_b), .done(done_b), .err(err_b), .aborted(abt_b), .stock(stk_b)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Reference model: a dispense is a timeline of count*(HI+LO) cycles counted
  // from acceptance, followed by one done cycle.
  int NT [2] = '{4, 5};
  int HI [2] = '{1, 3};
  int LO [2] = '{1, 2};
  int m_stock [2][8];
  bit m_act [2];
  int m_t [2], m_type [2], m_cnt [2];
  bit m_err [2], m_abt [2];

  function automatic int tmask(input int k, input logic [2:0] v);
    return (k == 0) ? int'(v[1:0]) : int'(v);
  endfunction

  task automatic model_step(input int k);
    int per, tot, ty, cnt, sub_ty, subc, ref_ty, refund, v;
    per = HI[k] + LO[k];
    tot = m_cnt[k] * per;
    sub_ty = -1; subc = 0; ref_ty = -1; refund = 0;
    m_err[k] = 1'b0;
    m_abt[k] = 1'b0;
    if (m_act[k]) begin
      if (m_t[k] <= tot && ab[k]) begin
        ref_ty = m_type[k];
        refund = m_cnt[k] - ((m_t[k] - 1) / per + 1);
        m_act[k] = 1'b0;
        m_abt[k] = 1'b1;
      end else if (m_t[k] == tot + 1) begin
        m_act[k] = 1'b0;
      end else begin
        m_t[k]++;
      end
    end else if (rv[k]) begin
      ty  = tmask(k, rt[k]);
      cnt = int'(rc[k]);
      if (ty >= NT[k] || cnt == 0 || m_stock[k][ty] < cnt) begin
        m_err[k] = 1'b1;
      end else begin
        sub_ty = ty; subc = cnt;
        m_act[k] = 1'b1; m_t[k] = 1; m_type[k] = ty; m_cnt[k] = cnt;
      end
    end
    for (int i = 0; i < NT[k]; i++) begin
      v = m_stock[k][i];
      if (i == sub_ty) v -= subc;
      if (i == ref_ty) v += refund;
      if (sv[k] && tmask(k, st[k]) == i) v += int'(sa[k]);
      m_stock[k][i] = (v > 255) ? 255 : v;
    end
  endtask

  task automatic model_check(input int k);
    int per, tot;
    bit e_busy, e_done;
    logic [7:0] e_iss, o_iss;
    logic [7:0] o_stk;
    string p;
    p = (k == 0) ? "A" : "B";
    per = HI[k] + LO[k];
    tot = m_cnt[k] * per;
    e_busy = m_act[k] && (m_t[k] <= tot);
    e_done = m_act[k] && (m_t[k] == tot + 1);
    e_iss  = (e_busy && ((m_t[k] - 1) % per) < HI[k]) ? (8'd1 << m_type[k]) : 8'd0;
    o_iss  = (k == 0) ? {4'b0, iss_a} : {3'b0, iss_b};
    check({p, ".ready"},   (k == 0) ? rdy_a  : rdy_b,  !m_act[k]);
    check({p, ".busy"},    (k == 0) ? busy_a : busy_b, e_busy);
    check({p, ".done"},    (k == 0) ? done_a : done_b, e_done);
    check({p, ".err"},     (k == 0) ? err_a  : err_b,  m_err[k]);
    check({p, ".aborted"}, (k == 0) ? abt_a  : abt_b,  m_abt[k]);
    check({p, ".issue"},   o_iss, e_iss);
    for (int i = 0; i < NT[k]; i++) begin
      o_stk = (k == 0) ? stk_a[i*8 +: 8] : stk_b[i*8 +: 8];
      check($sformatf("%s.stock%0d", p, i), o_stk, m_stock[k][i]);
    end
  endtask

  always @(negedge clk) begin
    for (int k = 0; k < 2; k++) begin
      if (rst) begin
        for (int i = 0; i < 8; i++) m_stock[k][i] = 20;
        m_act[k] = 1'b0; m_t[k] = 0; m_cnt[k] = 0; m_type[k] = 0;
        m_err[k] = 1'b0; m_abt[k] = 1'b0;
      end else begin
        model_step(k);
      end
      model_check(k);
    end
  end

  // Inputs change just after the falling edge, after the model has sampled them.
  task automatic cyc();
    @(negedge clk);
    #1;
  endtask

  initial begin
    for (int k = 0; k < 2; k++) begin
      rv[k] = 0; rt[k] = 0; rc[k] = 0; ab[k] = 0; sv[k] = 0; st[k] = 0; sa[k] = 0;
    end
    repeat (2) cyc();
    check("rst.ready_a", rdy_a, 1'b1);
    check("rst.stock_a2", stk_a[23:16], 8'd20);
    rst = 1'b0;

    // type 2 count 3 on A (1/1 pulses); type 2 count 2 on B (3/2 pulses)
    rv[0] = 1; rt[0] = 2; rc[0] = 3;
    rv[1] = 1; rt[1] = 2; rc[1] = 2;
    cyc();
    rv[0] = 0; rv[1] = 0;
    check("lat.first_issue_a", iss_a, 4'b0100);
    repeat (6) cyc();
    check("lat.done_a_c7", done_a, 1'b1);
    repeat (4) cyc();
    check("lat.done_b_c11", done_b, 1'b1);
    repeat (2) cyc();
    check("dir.stock_a2", stk_a[23:16], 8'd17);
    check("dir.stock_b2", stk_b[23:16], 8'd18);

    // count 0 on A, out-of-range type 5 on B
    rv[0] = 1; rt[0] = 1; rc[0] = 0;
    rv[1] = 1; rt[1] = 5; rc[1] = 1;
    cyc();
    rv[0] = 0; rv[1] = 0;
    check("rej.err_a", err_a, 1'b1);
    check("rej.err_b", err_b, 1'b1);
    cyc();

    // drain A type 1 down to 2, then over-request and saturating restock
    foreach (rc[0][j]) begin end
    for (int j = 0; j < 3; j++) begin
      rv[0] = 1; rt[0] = 1; rc[0] = (j == 2) ? 3'd4 : 3'd7;
      cyc();
      rv[0] = 0;
      repeat (2 * int'(rc[0]) + 1) cyc();
    end
    check("sat.stock_a1_low", stk_a[15:8], 8'd2);
    rv[0] = 1; rt[0] = 1; rc[0] = 3;
    cyc();
    rv[0] = 0;
    check("sat.err_a", err_a, 1'b1);
    sv[0] = 1; st[0] = 1; sa[0] = 250;
    cyc();
    check("sat.stock_a1_252", stk_a[15:8], 8'd252);
    sa[0] = 10;
    cyc();
    sv[0] = 0;
    check("sat.stock_a1_255", stk_a[15:8], 8'd255);

    // abort during the second HIGH of a 4-ticket dispense
    rv[0] = 1; rt[0] = 0; rc[0] = 4;
    cyc();
    rv[0] = 0;
    cyc();
    cyc();
    check("abt.second_high", iss_a, 4'b0001);
    ab[0] = 1;
    cyc();
    ab[0] = 0;
    check("abt.aborted_a", abt_a, 1'b1);
    check("abt.issue_a", iss_a, 4'b0000);
    check("abt.stock_a0", stk_a[7:0], 8'd18);

    // asynchronous reset while A is in LOW
    rv[0] = 1; rt[0] = 3; rc[0] = 2;
    rv[1] = 1; rt[1] = 3; rc[1] = 2;
    cyc();
    rv[0] = 0; rv[1] = 0;
    cyc();
    #2 rst = 1'b1;
    #1;
    check("arst.busy_a", busy_a, 1'b0);
    check("arst.issue_b", iss_b, 5'b0);
    check("arst.busy_b", busy_b, 1'b0);
    check("arst.stock_a3", stk_a[31:24], 8'd20);
    check("arst.stock_b3", stk_b[31:24], 8'd20);
    cyc();
    rst = 1'b0;
    rv[0] = 1; rt[0] = 3; rc[0] = 1;
    cyc();
    rv[0] = 0;
    check("arst.accept_after", iss_a, 4'b1000);
    repeat (10) cyc();

    // randomized traffic
    for (int n = 0; n < 3000; n++) begin
      for (int k = 0; k < 2; k++) begin
        rv[k] = ($urandom % 4) == 0;
        rt[k] = 3'($urandom);
        rc[k] = 3'($urandom);
        ab[k] = ($urandom % 16) == 0;
        sv[k] = ($urandom % 8) == 0;
        st[k] = 3'($urandom);
        sa[k] = (($urandom % 16) == 0) ? 8'($urandom) : 8'($urandom % 24);
      end
      cyc();
    end
    for (int k = 0; k < 2; k++) begin
      rv[k] = 0; ab[k] = 0; sv[k] = 0;
    end
    cyc();
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end

endmodule
